ultrasonic_ranger: RTL and testbench

Ranging front end for an HC-SR04-style ultrasonic sensor. It issues periodic trigger pulses, synchronises and times the echo pulse, and delivers a clean width sample with a one-cycle valid strobe, or a timeout strobe if no valid echo arrives. It sits directly upstream of the tone/LED mapping stage, which consumes only echo_width and sample_valid and performs no sensor timing of its own.

---
 rtl/ultrasonic_ranger.sv | 153 +++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - HC-SR04 ranging front end: periodic trigger, echo timing, valid/timeout strobes.
// Define RANGER_AVG_EN to replace the raw width with a running two-sample average.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 5000000,
  parameter int TIMEOUT_CYCLES = 150000,
  parameter int WIDTH          = 18
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ECH,
  output logic             TR,
  output logic [WIDTH-1:0] echo_width,
  output logic             sample_valid,
  output logic             timeout,
  output logic             busy
);

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam logic [PW-1:0]    P_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0]    T_LAST  = TW'(TRIG_CYCLES - 1);
  localparam logic [WIDTH-1:0] TO_MAX  = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] TO_WAIT = WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_HOLD
  } state_t;

  state_t           state, state_n;
  logic             run;
  logic [PW-1:0]    pcnt;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [WIDTH-1:0] cnt, cnt_n, ew_n;
  logic             ech_meta, ech_sync, ech_prev;
  logic             rise, fall, wrap, abort;
  logic             sv_n, to_n;
`ifdef RANGER_AVG_EN
  logic             have, have_n;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ech_meta <= 1'b0;
      ech_sync <= 1'b0;
      ech_prev <= 1'b0;
    end else begin
      ech_meta <= ECH;
      ech_sync <= ech_meta;
      ech_prev <= ech_sync;
    end
  end

  assign rise  = ech_sync & ~ech_prev;
  assign fall  = ~ech_sync & ech_prev;
  assign wrap  = (pcnt == P_LAST);
  assign abort = wrap && ((state == S_WAIT) || (state == S_MEAS));

  // run holds everything still for the first post-reset cycle so TR starts at period count 0
  assign TR   = run && (state == S_TRIG);
  assign busy = run && (state != S_HOLD);

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    cnt_n   = cnt;
    ew_n    = echo_width;
    sv_n    = 1'b0;
    to_n    = 1'b0;
`ifdef RANGER_AVG_EN
    have_n  = have;
`endif
    if (wrap) begin
      state_n = S_TRIG;
      tcnt_n  = '0;
      to_n    = abort;
    end else begin
      case (state)
        S_TRIG: begin
          if (tcnt == T_LAST) begin
            state_n = S_WAIT;
            cnt_n   = '0;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (rise) begin
            state_n = S_MEAS;
            cnt_n   = WIDTH'(1);
          end else if (cnt == TO_WAIT) begin
            state_n = S_HOLD;
            to_n    = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_MEAS: begin
          if (fall) begin
            state_n = S_HOLD;
            sv_n    = 1'b1;
`ifdef RANGER_AVG_EN
            have_n  = 1'b1;
            ew_n    = have ? WIDTH'(({1'b0, echo_width} + {1'b0, cnt}) >> 1) : cnt;
`else
            ew_n    = cnt;
`endif
          end else if (cnt == TO_MAX) begin
            state_n = S_HOLD;
            to_n    = 1'b1;
          end else if (ech_sync) begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      run          <= 1'b0;
      pcnt         <= '0;
      state        <= S_TRIG;
      tcnt         <= '0;
      cnt          <= '0;
      echo_width   <= '0;
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
`ifdef RANGER_AVG_EN
      have         <= 1'b0;
`endif
    end else begin
      run <= 1'b1;
      if (run) begin
        pcnt         <= wrap ? '0 : pcnt + 1'b1;
        state        <= state_n;
        tcnt         <= tcnt_n;
        cnt          <= cnt_n;
        echo_width   <= ew_n;
        sample_valid <= sv_n;
        timeout      <= to_n;
`ifdef RANGER_AVG_EN
        have         <= have_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - self-checking bench for ultrasonic_ranger (TRIG=4, PERIOD=200, TIMEOUT=50, WIDTH=8).
module tb_ultrasonic_ranger;

  localparam int TRIG    = 4;
  localparam int PERIOD  = 200;
  localparam int TMO     = 50;
  localparam int W       = 8;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         ECH   = 1'b0;
  logic         TR;
  logic [W-1:0] echo_width;
  logic         sample_valid;
  logic         timeout;
  logic         busy;

  int compared   = 0;
  int mismatched = 0;
  int model_ew   = 0;
  bit model_have = 1'b0;

  typedef struct {
    int lo;
    int n;
    bit ev;
    int at;
    int w;
  } vec_t;

  vec_t vecs[10];

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG),
    .PERIOD_CYCLES(PERIOD),
    .TIMEOUT_CYCLES(TMO),
    .WIDTH(W)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .ECH(ECH),
    .TR(TR),
    .echo_width(echo_width),
    .sample_valid(sample_valid),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  // Inputs for cycle o are driven just after its opening edge; outputs are sampled mid-cycle.
  task automatic step(input bit ech, input bit rst, input logic [W+3:0] exp, input string tag, input int o);
    logic [W+3:0] got;
    @(posedge CLOCK);
    #1;
    ECH   = ech;
    RESET = rst;
    @(negedge CLOCK);
    got = {TR, busy, sample_valid, timeout, echo_width};
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s o=%0d: got TR=%b busy=%b sv=%b to=%b ew=%0d, want TR=%b busy=%b sv=%b to=%b ew=%0d",
               tag, o, got[W+3], got[W+2], got[W+1], got[W], got[W-1:0],
               exp[W+3], exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic take_sample(input int w);
`ifdef RANGER_AVG_EN
    model_ew = model_have ? (model_ew + w) / 2 : w;
`else
    model_ew = w;
`endif
    model_have = 1'b1;
  endtask

  // One full measurement period; ECH high for offsets [lo,hi); strobe expected at offset at.
  task automatic run_period(input int lo, input int hi, input bit ev, input int at, input int w, input string tag);
    for (int o = 0; o < PERIOD; o++) begin
      if (ev && o == at) take_sample(w);
      step(o >= lo && o < hi, 1'b0,
           {o < TRIG, o < at, ev && o == at, !ev && o == at, 8'(model_ew)}, tag, o);
    end
  endtask

  // Reference rules: echo rise at offset lo is seen if WAIT_RISE is active two cycles later;
  // widths above TIMEOUT abort; strobes land 3 cycles after the relevant ECH edge.
  task automatic predict(input int lo, input int n, output bit ev, output int at);
    int fall_t;
    if (n == 0 || lo + 2 < TRIG || lo + 2 > TRIG + TMO - 1) begin
      ev = 1'b0;
      at = TRIG + TMO;
    end else if (n > TMO) begin
      ev = 1'b0;
      at = lo + TMO + 3;
    end else begin
      fall_t = lo + n;
      ev = 1'b1;
      at = fall_t + 3;
    end
  endtask

  initial begin
    bit ev;
    int at, lo, n;

    vecs[0] = '{9, 20, 1'b1, 32, 20};
    vecs[1] = '{0, 0, 1'b0, 54, 0};
    vecs[2] = '{9, 40, 1'b1, 52, 40};
    vecs[3] = '{51, 3, 1'b1, 57, 3};
    vecs[4] = '{52, 3, 1'b0, 54, 0};
    vecs[5] = '{2, 10, 1'b1, 15, 10};
    vecs[6] = '{1, 10, 1'b0, 54, 0};
    vecs[7] = '{4, 50, 1'b1, 57, 50};
    vecs[8] = '{4, 51, 1'b0, 57, 0};
    vecs[9] = '{14, 1, 1'b1, 18, 1};

    step(1'b0, 1'b1, '0, "reset", 0);
    step(1'b0, 1'b1, '0, "reset", 1);
    step(1'b0, 1'b0, '0, "reset", 2);

    for (int i = 0; i < 10; i++)
      run_period(vecs[i].lo, vecs[i].lo + vecs[i].n, vecs[i].ev, vecs[i].at, vecs[i].w,
                 $sformatf("vec%0d", i));

    run_period(9, PERIOD, 1'b0, 62, 0, "stuck_rise");
    run_period(0, PERIOD, 1'b0, 54, 0, "stuck_high");
    run_period(0, 0, 1'b0, 54, 0, "stuck_release");

    for (int i = 0; i < 12; i++) begin
      lo = int'($urandom_range(0, 64));
      n  = int'($urandom_range(0, 60));
      predict(lo, n, ev, at);
      run_period(lo, lo + n, ev, at, n, $sformatf("rand%0d", i));
    end

    // Reset pulse while MEASURE holds width 10 (cycle 21 of a period with echo from offset 9).
    for (int o = 0; o < 21; o++)
      step(o >= 9, 1'b0, {o < TRIG, 1'b1, 1'b0, 1'b0, 8'(model_ew)}, "midreset", o);
    step(1'b1, 1'b1, {1'b0, 1'b1, 1'b0, 1'b0, 8'(model_ew)}, "midreset", 21);
    model_ew   = 0;
    model_have = 1'b0;
    step(1'b0, 1'b0, '0, "midreset_clear", 22);
    run_period(0, 0, 1'b0, 54, 0, "after_reset");
    run_period(9, 29, 1'b1, 32, 20, "after_reset_echo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
